// File: rtl/regs_pkg.sv
// Shared definitions for the register-file write arbiter.
// Holds the default address/data widths, the requester id type and the
// per-requester queue depth (2 entries).
package regs_pkg;

  localparam int REGS_AW_DEF = 4;
  localparam int REGS_DW_DEF = 16;

  localparam int FIFO_DEPTH  = 2;
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regs_wr_fifo.sv
// Two-entry in-order write queue for one requester.
// Entry 0 is always the head; a pop shifts entry 1 down.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_push, i_pop         enqueue / dequeue strobes (ignored when full / empty)
//   i_push_addr/data      entry written on push
//   o_head_addr/data      oldest entry
//   o_count               registered occupancy (0..2)
//   o_ent_addr, o_ent_vld per-entry address and valid, for read-pending match
module regs_wr_fifo
  import regs_pkg::*;
#(
  parameter int AW = REGS_AW_DEF,
  parameter int DW = REGS_DW_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [AW-1:0]                    i_push_addr,
  input  logic [DW-1:0]                    i_push_data,
  output logic [AW-1:0]                    o_head_addr,
  output logic [DW-1:0]                    o_head_data,
  output logic [CNT_W-1:0]                 o_count,
  output logic [FIFO_DEPTH-1:0][AW-1:0]    o_ent_addr,
  output logic [FIFO_DEPTH-1:0]            o_ent_vld
);

  logic [FIFO_DEPTH-1:0][AW-1:0] r_addr;
  logic [FIFO_DEPTH-1:0][DW-1:0] r_data;
  logic [CNT_W-1:0]              r_cnt;

  logic w_push;
  logic w_pop;
  logic w_wr_idx;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && (r_cnt < CNT_FULL);

  // A push only happens with 0 or 1 entries held, so the write slot is
  // entry 1 only when one entry stays put (count 1, no pop this cycle).
  assign w_wr_idx = r_cnt[0] && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) begin
        r_addr[0] <= r_addr[1];
        r_data[0] <= r_data[1];
      end
      // Placed after the shift so a push into slot 0 wins over it.
      if (w_push) begin
        r_addr[w_wr_idx] <= i_push_addr;
        r_data[w_wr_idx] <= i_push_data;
      end
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head_addr  = r_addr[0];
  assign o_head_data  = r_data[0];
  assign o_count      = r_cnt;
  assign o_ent_addr   = r_addr;
  assign o_ent_vld[0] = (r_cnt != '0);
  assign o_ent_vld[1] = (r_cnt == CNT_FULL);

endmodule

// File: rtl/regs_wr_arb.sv
// Round-robin write arbiter in front of a register file.
// Two requesters (A, B) each feed a 2-entry queue; every cycle one non-empty
// queue head is granted and loaded into a registered write port.
// Optional feature: define REGS_WR_PEND_EN to build read-after-write pending
// detection on rd0_pend/rd1_pend; otherwise they are tied low.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data  requester A write handshake
//   b_valid/b_ready/b_addr/b_data  requester B write handshake
//   wen, waddr, wdata          registered register-file write port
//   raddr0, raddr1             read addresses being issued to the register file
//   rd0_pend, rd1_pend         a write to raddr0 / raddr1 is still in flight
module regs_wr_arb
  import regs_pkg::*;
#(
  parameter int AW = REGS_AW_DEF,
  parameter int DW = REGS_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic          rd0_pend,
  output logic          rd1_pend
);

  logic [CNT_W-1:0]              w_cnt_a,   w_cnt_b;
  logic [AW-1:0]                 w_head_addr_a, w_head_addr_b;
  logic [DW-1:0]                 w_head_data_a, w_head_data_b;
  logic [FIFO_DEPTH-1:0][AW-1:0] w_eaddr_a, w_eaddr_b;
  logic [FIFO_DEPTH-1:0]         w_vld_a,   w_vld_b;
  logic                          w_ne_a,    w_ne_b;
  logic                          w_gnt_a,   w_gnt_b;

  req_id_e       r_last;
  logic          r_wen;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not open a slot until the next cycle.
  assign a_ready = (w_cnt_a < CNT_FULL);
  assign b_ready = (w_cnt_b < CNT_FULL);

  regs_wr_fifo #(.AW(AW), .DW(DW)) u_fifo_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (a_valid && a_ready),
    .i_pop       (w_gnt_a),
    .i_push_addr (a_addr),
    .i_push_data (a_data),
    .o_head_addr (w_head_addr_a),
    .o_head_data (w_head_data_a),
    .o_count     (w_cnt_a),
    .o_ent_addr  (w_eaddr_a),
    .o_ent_vld   (w_vld_a)
  );

  regs_wr_fifo #(.AW(AW), .DW(DW)) u_fifo_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (b_valid && b_ready),
    .i_pop       (w_gnt_b),
    .i_push_addr (b_addr),
    .i_push_data (b_data),
    .o_head_addr (w_head_addr_b),
    .o_head_data (w_head_data_b),
    .o_count     (w_cnt_b),
    .o_ent_addr  (w_eaddr_b),
    .o_ent_vld   (w_vld_b)
  );

  assign w_ne_a = (w_cnt_a != '0);
  assign w_ne_b = (w_cnt_b != '0);

  // A wins on contention unless it was granted last.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_ne_a && (!w_ne_b || (r_last == REQ_B))) begin
      w_gnt_a = 1'b1;
    end else if (w_ne_b) begin
      w_gnt_b = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= REQ_B;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_gnt_a || w_gnt_b;
      if (w_gnt_a) begin
        r_last  <= REQ_A;
        r_waddr <= w_head_addr_a;
        r_wdata <= w_head_data_a;
      end else if (w_gnt_b) begin
        r_last  <= REQ_B;
        r_waddr <= w_head_addr_b;
        r_wdata <= w_head_data_b;
      end
    end
  end

  assign wen   = r_wen;
  assign waddr = r_waddr;
  assign wdata = r_wdata;

`ifdef REGS_WR_PEND_EN
  logic w_pend0;
  logic w_pend1;

  always_comb begin
    w_pend0 = r_wen && (r_waddr == raddr0);
    w_pend1 = r_wen && (r_waddr == raddr1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_vld_a[i] && (w_eaddr_a[i] == raddr0)) w_pend0 = 1'b1;
      if (w_vld_b[i] && (w_eaddr_b[i] == raddr0)) w_pend0 = 1'b1;
      if (w_vld_a[i] && (w_eaddr_a[i] == raddr1)) w_pend1 = 1'b1;
      if (w_vld_b[i] && (w_eaddr_b[i] == raddr1)) w_pend1 = 1'b1;
    end
  end

  assign rd0_pend = w_pend0;
  assign rd1_pend = w_pend1;
`else
  // Pending detection not built: read addresses and entry taps are unused.
  logic w_unused_pend;
  assign w_unused_pend = ^{raddr0, raddr1, w_eaddr_a, w_eaddr_b, w_vld_a, w_vld_b};
  assign rd0_pend = 1'b0;
  assign rd1_pend = 1'b0;
`endif

endmodule

// File: doc/regs_wr_arb.md
REGS_WR_ARB -- requirements
Module: regs_wr_arb

Interface
REQ-001 Parameter AW, default 4, is the register address width.
REQ-002 Parameter DW, default 16, is the register data width.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 a_valid  input  1  indicates requester A write request.
REQ-006 a_ready  output  1  indicates requester A FIFO can accept.
REQ-007 a_addr  input  AW  is requester A destination register.
REQ-008 a_data  input  DW  is requester A write data.
REQ-009 b_valid, b_ready, b_addr, b_data SHALL be identical in direction, width and meaning to the A ports, for requester B.
REQ-010 wen  output  1  is the register-file write enable.
REQ-011 waddr  output  AW  is the register-file write address.
REQ-012 wdata  output  DW  is the register-file write data.
REQ-013 raddr0, raddr1  input  AW  are the read addresses being issued to the register file.
REQ-014 rd0_pend, rd1_pend  output  1  indicate a write to raddr0 / raddr1 is still in flight.

Function
REQ-015 Each requester SHALL own a 2-entry in-order FIFO; handshake = valid && ready at a rising edge.
REQ-016 x_ready SHALL equal (FIFO count < 2), from registered count only; pop in the same cycle does not raise ready.
REQ-017 Request data is sampled only on handshake; valid while ready low SHALL have no effect.
REQ-018 Each cycle, if any FIFO is non-empty, exactly one head SHALL be granted, popped, and loaded into the output register.
REQ-019 Arbitration SHALL be round-robin: with both non-empty, grant the requester not granted last; with one non-empty, grant it.
REQ-020 The last-grant pointer SHALL update only on a grant.
REQ-021 Latency: handshake at edge E0 into an empty FIFO, both FIFOs otherwise empty -> wen, waddr, wdata valid from E1 to E2; register file commits at E2.
REQ-022 wen SHALL be 0 in any cycle following a cycle with no grant; waddr/wdata hold their last values.
REQ-023 Per-requester write order SHALL be preserved; cross-requester order equals grant order, including writes to the same address.
REQ-024 Sustained throughput SHALL be one write per cycle while any FIFO is non-empty.
REQ-025 rdN_pend SHALL be combinational: 1 iff raddrN matches the address of any valid FIFO entry (A or B) or of the output register while wen is 1.

Reset
REQ-026 While rst_n is 0: both FIFOs empty, a_ready = b_ready = 1 after release, wen = 0, waddr = 0, wdata = 0, last-grant pointer = B (A wins first contention), rd0_pend = rd1_pend = 0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight writes; no wen pulse is generated by reset deassertion.

Configuration
REQ-028 Macro REGS_WR_PEND_EN: when defined, REQ-025 pending detection is built.
REQ-029 Without REGS_WR_PEND_EN, rd0_pend and rd1_pend SHALL be tied to 0; raddr0/raddr1 are ignored; ports remain present.

Structure
REQ-030 Package regs_pkg SHALL hold AW/DW defaults, the requester-id enum (REQ_A, REQ_B), and FIFO depth constant 2.
REQ-031 Sub-module regs_wr_fifo (2-entry FIFO: push, pop, head, count, per-entry addr/valid exposed for pending match) SHALL be instantiated once per requester.

Verification
REQ-032 Single A write, addr 3, data 0x1234, at E0 -> wen = 1, waddr = 3, wdata = 0x1234 in cycle E1-E2 only; a_ready stays 1.
REQ-033 A and B both valid every cycle, 4 writes each -> grants alternate A,B,A,B,...; 8 consecutive wen cycles; per-requester data order preserved.
REQ-034 A pushes 3 writes back-to-back, no pops possible (B earlier filling output) -> a_ready drops to 0 after 2 queued, third accepted only once count < 2.
REQ-035 A and B both write addr 5 (A 0x00AA, B 0x00BB) same edge after reset -> A committed first, B second; final r5 = 0x00BB.
REQ-036 REGS_WR_PEND_EN defined, A write to addr 7 queued, raddr0 = 7, raddr1 = 2 -> rd0_pend = 1 until the cycle after the wen cycle for addr 7, rd1_pend = 0 throughout; macro undefined -> both always 0.
REQ-037 rst_n pulled low with both FIFOs full and wen = 1 -> wen = 0 immediately, both ready = 1 after release, no writes appear afterwards.
